// File: rtl/led_chaser_pkg.sv
// Shared encodings for the LED chaser: display modes and bounce direction.
package led_chaser_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'b00,
    MODE_SOLID  = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Modes in which the display tick moves the position by itself.
  function automatic logic tick_moves(input mode_e m);
    return (m == MODE_AUTO) || (m == MODE_BOUNCE);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-key conditioner: 2-flop synchroniser, stable-count debounce, and a
// one-cycle press pulse on each accepted rising level.
module key_debounce
  import led_chaser_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept the synchronised level only after DEBOUNCE_CYC consecutive mismatches.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/led_chaser.sv
// N-LED position indicator/chaser: key-stepped or tick-driven one-hot position
// with blink, solid, auto-chase and bounce display modes.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int unsigned N_LED        = 8,
  parameter int unsigned TICK_DIV     = 25_000_000,
  parameter int unsigned DEBOUNCE_CYC = 250_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_next,
  input  logic                       key_prev,
  input  logic [1:0]                 mode,
  output logic [N_LED-1:0]           led,
  output logic [$clog2(N_LED)-1:0]   pos,
  output logic                       tick
);

  localparam int unsigned       POS_W     = $clog2(N_LED);
  localparam int unsigned       TICK_W    = $clog2(TICK_DIV);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(N_LED - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic              next_press, prev_press;
  logic              next_level, prev_level;
  logic              unused_levels;

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick_q, tick_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [POS_W-1:0]  pos_up, pos_dn;
  dir_e              dir_q, dir_d;
  logic              blink_q, blink_d;
  mode_e             mode_q, mode_d;
  mode_e             mode_in;
  logic [N_LED-1:0]  led_q, led_d;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_next (
    .clk   (clk),
    .rst   (rst),
    .din   (key_next),
    .level (next_level),
    .press (next_press)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_prev (
    .clk   (clk),
    .rst   (rst),
    .din   (key_prev),
    .level (prev_level),
    .press (prev_press)
  );

  assign unused_levels = next_level ^ prev_level;
  assign mode_in       = mode_e'(mode);

  // Free-running display tick; pulse lands in the cycle the counter is at its last value.
  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
    tick_d     = (tick_cnt_d == TICK_LAST);
  end

  // Position, direction and blink phase; keys outrank the tick-driven move.
  always_comb begin
    pos_d   = pos_q;
    dir_d   = dir_q;
    blink_d = blink_q;
    mode_d  = mode_in;
    pos_up  = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
    pos_dn  = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);

    if (next_press && !prev_press) begin
      pos_d = pos_up;
    end else if (prev_press && !next_press) begin
      pos_d = pos_dn;
    end else if (!next_press && !prev_press && tick_q && tick_moves(mode_in)) begin
      if (mode_in == MODE_AUTO) begin
        pos_d = pos_up;
      end else if (dir_q == DIR_UP) begin
        if (pos_q == POS_LAST) begin
          dir_d = DIR_DOWN;
          pos_d = pos_dn;
        end else begin
          pos_d = pos_up;
        end
      end else begin
        if (pos_q == '0) begin
          dir_d = DIR_UP;
          pos_d = pos_up;
        end else begin
          pos_d = pos_dn;
        end
      end
    end

    if (mode_in != MODE_BLINK) begin
      blink_d = 1'b1;
    end else if (tick_q) begin
      blink_d = ~blink_q;
    end
    // A visible change always lights the LED so the new position is shown at once.
    if ((pos_d != pos_q) || (mode_in != mode_q)) begin
      blink_d = 1'b1;
    end

    led_d = blink_d ? (N_LED'(1) << pos_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      pos_q      <= '0;
      dir_q      <= DIR_UP;
      blink_q    <= 1'b1;
      mode_q     <= MODE_BLINK;
      led_q      <= N_LED'(1);
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      blink_q    <= blink_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
    end
  end

  assign led  = led_q;
  assign pos  = pos_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_chaser.sv
// Scoreboard bench for led_chaser (N_LED=4, TICK_DIV=4, DEBOUNCE_CYC=3).
`timescale 1ns/1ps
module tb_led_chaser;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_next;
  logic       key_prev;
  logic [1:0] mode;
  logic [3:0] led;
  logic [1:0] pos;
  logic       tick;
  logic [1:0] press_obs;

  always #5 clk = ~clk;

  led_chaser #(.N_LED(4), .TICK_DIV(4), .DEBOUNCE_CYC(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_next (key_next),
    .key_prev (key_prev),
    .mode     (mode),
    .led      (led),
    .pos      (pos),
    .tick     (tick)
  );

  assign press_obs = {dut.u_key_next.press, dut.u_key_prev.press};

  typedef struct {
    int           cyc;
    logic [3:0]   led;
    logic [1:0]   pos;
    bit           chk_tick;
    logic         tick;
    bit           chk_press;
    logic [1:0]   press;
    logic [127:0] name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   r0, r1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare each expectation in the cycle it is tagged with.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_chk = n_chk + 1;
      if (mon_e.cyc != cyc) begin
        n_fail = n_fail + 1;
        $display("FAIL %0s: expectation for cycle %0d not checked in time (now %0d)",
                 mon_e.name, mon_e.cyc, cyc);
      end else if (led !== mon_e.led || pos !== mon_e.pos ||
                   (mon_e.chk_tick && tick !== mon_e.tick) ||
                   (mon_e.chk_press && press_obs !== mon_e.press)) begin
        n_fail = n_fail + 1;
        $display("FAIL %0s @%0d: got led=%b pos=%0d tick=%b press=%b, want led=%b pos=%0d tick=%b(chk %0d) press=%b(chk %0d)",
                 mon_e.name, cyc, led, pos, tick, press_obs, mon_e.led, mon_e.pos,
                 mon_e.tick, mon_e.chk_tick, mon_e.press, mon_e.chk_press);
      end
    end
  end

  task automatic push(input int c, input logic [3:0] l, input logic [1:0] p,
                      input bit ct, input logic t, input bit cp, input logic [1:0] pr,
                      input logic [127:0] nm);
    exp_t e;
    int   i;
    e.cyc = c; e.led = l; e.pos = p; e.chk_tick = ct; e.tick = t;
    e.chk_press = cp; e.press = pr; e.name = nm;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  task automatic exp_lp(input int c, input logic [3:0] l, input logic [1:0] p, input logic [127:0] nm);
    push(c, l, p, 1'b0, 1'b0, 1'b0, 2'b00, nm);
  endtask

  task automatic exp_tk(input int c, input logic [3:0] l, input logic [1:0] p, input logic t,
                        input logic [127:0] nm);
    push(c, l, p, 1'b1, t, 1'b0, 2'b00, nm);
  endtask

  task automatic chk(input logic [127:0] nm, input logic [31:0] act, input logic [31:0] req);
    n_chk = n_chk + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %0s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic wait_cyc(input int c);
    if (cyc > c) begin
      n_chk  = n_chk + 1;
      n_fail = n_fail + 1;
      $display("FAIL sched: cycle %0d already passed (now %0d)", c, cyc);
    end
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One debounced press: key held 5 cycles, pos changes 6 cycles after the key edge.
  task automatic press_key(input bit is_next, input int t,
                           input logic [1:0] p0, input logic [3:0] l0,
                           input logic [1:0] p1, input logic [3:0] l1,
                           input logic [127:0] nm);
    wait_cyc(t);
    if (is_next) key_next = 1'b1;
    else         key_prev = 1'b1;
    exp_lp(t + 5, l0, p0, nm);
    exp_lp(t + 6, l1, p1, nm);
    wait_cyc(t + 5);
    key_next = 1'b0;
    key_prev = 1'b0;
    wait_cyc(t + 12);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; key_next = 1'b0; key_prev = 1'b0; mode = 2'b00;
    @(posedge clk); #1;
    chk("rst_led", 32'(led), 32'h1);
    chk("rst_pos", 32'(pos), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    r0  = cyc;

    // Blink from reset: tick every 4th cycle, phase toggles after each tick.
    exp_tk(r0 + 1, 4'b0001, 2'd0, 1'b0, "blink_c1");
    exp_tk(r0 + 3, 4'b0001, 2'd0, 1'b1, "blink_t3");
    exp_tk(r0 + 4, 4'b0000, 2'd0, 1'b0, "blink_off");
    exp_tk(r0 + 7, 4'b0000, 2'd0, 1'b1, "blink_t7");
    exp_lp(r0 + 8, 4'b0001, 2'd0, "blink_on");
    wait_cyc(r0 + 9);
    mode = 2'b01;
    exp_lp(r0 + 12, 4'b0001, 2'd0, "solid_hold");

    // Held key: exactly one step, 6 cycles after the edge.
    wait_cyc(r0 + 14);
    key_next = 1'b1;
    exp_lp(r0 + 19, 4'b0001, 2'd0, "hold_pre");
    exp_lp(r0 + 20, 4'b0010, 2'd1, "hold_step");
    exp_lp(r0 + 34, 4'b0010, 2'd1, "hold_once");
    wait_cyc(r0 + 34);
    key_next = 1'b0;
    wait_cyc(r0 + 42);

    press_key(1'b1, r0 + 42, 2'd1, 4'b0010, 2'd2, 4'b0100, "next_1to2");
    press_key(1'b1, r0 + 54, 2'd2, 4'b0100, 2'd3, 4'b1000, "next_2to3");
    press_key(1'b1, r0 + 66, 2'd3, 4'b1000, 2'd0, 4'b0001, "next_wrap");
    press_key(1'b0, r0 + 78, 2'd0, 4'b0001, 2'd3, 4'b1000, "prev_wrap");

    // Two-cycle glitch must not be accepted.
    key_next = 1'b1;
    wait_cyc(r0 + 92);
    key_next = 1'b0;
    exp_lp(r0 + 98, 4'b1000, 2'd3, "glitch_a");
    exp_lp(r0 + 102, 4'b1000, 2'd3, "glitch_b");
    wait_cyc(r0 + 104);

    // Both keys together: both pulses coincide, no move.
    key_next = 1'b1; key_prev = 1'b1;
    push(r0 + 109, 4'b1000, 2'd3, 1'b0, 1'b0, 1'b1, 2'b11, "both_pulse");
    exp_lp(r0 + 110, 4'b1000, 2'd3, "both_nomove");
    exp_lp(r0 + 114, 4'b1000, 2'd3, "both_later");
    wait_cyc(r0 + 109);
    key_next = 1'b0; key_prev = 1'b0;
    wait_cyc(r0 + 116);
    press_key(1'b0, r0 + 116, 2'd3, 4'b1000, 2'd2, 4'b0100, "prev_3to2");

    // Asynchronous reset between edges with pos=2.
    chk("pre_rst_pos", 32'(pos), 32'h2);
    #3;
    mode = 2'b00;
    rst  = 1'b1;
    #1;
    chk("arst_led", 32'(led), 32'h1);
    chk("arst_pos", 32'(pos), 32'h0);
    chk("arst_tick", 32'(tick), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    r1  = cyc;
    exp_tk(r1 + 2, 4'b0001, 2'd0, 1'b0, "arst_c2");
    exp_tk(r1 + 3, 4'b0001, 2'd0, 1'b1, "arst_t3");
    exp_tk(r1 + 4, 4'b0000, 2'd0, 1'b0, "arst_c4");
    exp_tk(r1 + 7, 4'b0000, 2'd0, 1'b1, "arst_t7");
    exp_tk(r1 + 11, 4'b0001, 2'd0, 1'b1, "arst_t11");
    exp_tk(r1 + 12, 4'b0000, 2'd0, 1'b0, "arst_c12");

    // Auto chase 0,1,2,3,0.
    wait_cyc(r1 + 12);
    mode = 2'b10;
    exp_lp(r1 + 14, 4'b0001, 2'd0, "auto_0");
    exp_tk(r1 + 15, 4'b0001, 2'd0, 1'b1, "auto_tick");
    exp_lp(r1 + 16, 4'b0010, 2'd1, "auto_1");
    exp_lp(r1 + 20, 4'b0100, 2'd2, "auto_2");
    exp_lp(r1 + 24, 4'b1000, 2'd3, "auto_3");
    exp_lp(r1 + 27, 4'b1000, 2'd3, "auto_3b");
    exp_lp(r1 + 28, 4'b0001, 2'd0, "auto_wrap");

    // Bounce 0,1,2,3,2,1,0,1.
    wait_cyc(r1 + 28);
    mode = 2'b11;
    exp_lp(r1 + 29, 4'b0001, 2'd0, "bnc_0");
    exp_lp(r1 + 32, 4'b0010, 2'd1, "bnc_1");
    exp_lp(r1 + 36, 4'b0100, 2'd2, "bnc_2");
    exp_lp(r1 + 40, 4'b1000, 2'd3, "bnc_3");
    exp_lp(r1 + 44, 4'b0100, 2'd2, "bnc_top");
    exp_lp(r1 + 48, 4'b0010, 2'd1, "bnc_1d");
    exp_lp(r1 + 52, 4'b0001, 2'd0, "bnc_0d");
    exp_lp(r1 + 56, 4'b0010, 2'd1, "bnc_bottom");

    // Auto with a press pulse on the same cycle as a tick: single step.
    wait_cyc(r1 + 56);
    mode = 2'b10;
    exp_lp(r1 + 60, 4'b0100, 2'd2, "auto2_2");
    exp_lp(r1 + 68, 4'b0001, 2'd0, "auto2_0");
    exp_lp(r1 + 72, 4'b0010, 2'd1, "auto2_1");
    wait_cyc(r1 + 70);
    key_next = 1'b1;
    push(r1 + 75, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1, 2'b10, "coinc_pre");
    exp_lp(r1 + 76, 4'b0100, 2'd2, "coinc_step");
    exp_tk(r1 + 79, 4'b0100, 2'd2, 1'b1, "coinc_hold");
    exp_lp(r1 + 80, 4'b1000, 2'd3, "coinc_next");
    wait_cyc(r1 + 75);
    key_next = 1'b0;

    // Blink dark phase, prev press lights the new LED immediately.
    wait_cyc(r1 + 84);
    mode     = 2'b00;
    key_prev = 1'b1;
    exp_lp(r1 + 86, 4'b0001, 2'd0, "bprev_lit");
    exp_lp(r1 + 88, 4'b0000, 2'd0, "bprev_dark");
    push(r1 + 89, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 2'b01, "bprev_pulse");
    exp_lp(r1 + 90, 4'b1000, 2'd3, "bprev_move");
    exp_lp(r1 + 92, 4'b0000, 2'd3, "bprev_blink");
    wait_cyc(r1 + 89);
    key_prev = 1'b0;
    wait_cyc(r1 + 96);

    for (int i = 0; i < 50 && sb.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
